// File: rtl/p_hardisc.sv
// Shared definitions for the execute-stage divide sequencer.
package p_hardisc;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [1:0] DIV_FN_DIV  = 2'b00;
   localparam logic [1:0] DIV_FN_DIVU = 2'b01;
   localparam logic [1:0] DIV_FN_REM  = 2'b10;
   localparam logic [1:0] DIV_FN_REMU = 2'b11;

   typedef logic [1:0] div_state_t;

   localparam div_state_t DIV_IDLE  = 2'd0;
   localparam div_state_t DIV_RUN   = 2'd1;
   localparam div_state_t DIV_FIXUP = 2'd2;
   localparam div_state_t DIV_DONE  = 2'd3;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step
   import p_hardisc::*;
(
   input  logic [XLEN-1:0] rem,
   input  logic            dvd_msb,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next_c,
   output logic            q_bit_c
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // A borrow out of the 33-bit subtract means the trial divisor did not fit.
   always_comb begin
      shifted    = {rem, dvd_msb};
      diff       = shifted - {1'b0, divisor};
      q_bit_c    = ~diff[XLEN];
      rem_next_c = q_bit_c ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/mdu_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: 32 restoring iterations plus sign fixup.
module mdu_div_seq
   import p_hardisc::*;
#(
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic            s_clk_i,
   input  logic            s_reset_i,
   input  logic            s_stall_i,
   input  logic            s_flush_i,
   input  logic            s_start_i,
   input  logic [1:0]      s_function_i,
   input  logic [XLEN-1:0] s_operand1_i,
   input  logic [XLEN-1:0] s_operand2_i,
   output logic            s_busy_o,
   output logic            s_finished_o,
   output logic [XLEN-1:0] s_result_o
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  dvd_q, dvd_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             sel_rem_q, sel_rem_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             finished_q, finished_d;
   logic             busy_q, busy_d;

   logic             signed_op, sign1, sign2, div_zero, overflow;
   logic [XLEN-1:0]  abs1, abs2;
   logic [XLEN-1:0]  step_rem;
   logic             step_bit;

   // Operand preparation for the operation being accepted in IDLE.
   always_comb begin
      signed_op = ~s_function_i[0];
      sign1     = signed_op & s_operand1_i[XLEN-1];
      sign2     = signed_op & s_operand2_i[XLEN-1];
      abs1      = sign1 ? (~s_operand1_i + XLEN'(1)) : s_operand1_i;
      abs2      = sign2 ? (~s_operand2_i + XLEN'(1)) : s_operand2_i;
      div_zero  = (s_operand2_i == '0);
      overflow  = signed_op && (s_operand1_i == INT_MIN) && (s_operand2_i == '1);
   end

   div_step u_step (
      .rem        (rem_q),
      .dvd_msb    (dvd_q[XLEN-1]),
      .divisor    (dvs_q),
      .rem_next_c (step_rem),
      .q_bit_c    (step_bit)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      sel_rem_d = sel_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      case (state_q)
         DIV_IDLE: begin
            if (s_start_i) begin
               sel_rem_d = s_function_i[1];
               neg_quo_d = (sign1 ^ sign2) & ~div_zero;
               neg_rem_d = sign1;
               dvd_d     = abs1;
               dvs_d     = abs2;
               rem_d     = '0;
               cnt_d     = CNT_W'(XLEN - 1);
               if (FAST_SPECIAL && div_zero) begin
                  result_d = s_function_i[1] ? s_operand1_i : '1;
                  state_d  = DIV_DONE;
               end else if (FAST_SPECIAL && overflow) begin
                  result_d = s_function_i[1] ? '0 : INT_MIN;
                  state_d  = DIV_DONE;
               end else begin
                  state_d  = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[XLEN-2:0], step_bit};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = DIV_FIXUP;
         end
         DIV_FIXUP: begin
            if (sel_rem_q) result_d = neg_rem_q ? (~rem_q + XLEN'(1)) : rem_q;
            else           result_d = neg_quo_q ? (~dvd_q + XLEN'(1)) : dvd_q;
            state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (!s_stall_i) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase

      // Flush wins over start and over completion.
      if (s_flush_i) state_d = DIV_IDLE;

      finished_d = (state_d == DIV_DONE);
      busy_d     = (state_d != DIV_IDLE);
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state_q    <= DIV_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         result_q   <= '0;
         sel_rem_q  <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         finished_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         result_q   <= result_d;
         sel_rem_q  <= sel_rem_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         finished_q <= finished_d;
         busy_q     <= busy_d;
      end
   end

   assign s_busy_o     = busy_q;
   assign s_finished_o = finished_q;
   assign s_result_o   = result_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Scoreboard bench for mdu_div_seq, run with fast special cases on and off in lockstep.
module tb_mdu_div_seq;
   import p_hardisc::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush, start;
   logic [1:0]  fn;
   logic [31:0] op1, op2;
   logic [1:0]  busy, fin;
   logic [31:0] res [2];

   typedef struct {
      logic [31:0] res;
      int          start_cyc;
      int          lat;
      int          hold;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc;
   int   tests_run;
   int   tests_failed;

   always #5 clk = ~clk;

   mdu_div_seq #(.FAST_SPECIAL(1'b1)) u_fast (
      .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall), .s_flush_i(flush),
      .s_start_i(start), .s_function_i(fn), .s_operand1_i(op1), .s_operand2_i(op2),
      .s_busy_o(busy[0]), .s_finished_o(fin[0]), .s_result_o(res[0])
   );

   mdu_div_seq #(.FAST_SPECIAL(1'b0)) u_slow (
      .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall), .s_flush_i(flush),
      .s_start_i(start), .s_function_i(fn), .s_operand1_i(op1), .s_operand2_i(op2),
      .s_busy_o(busy[1]), .s_finished_o(fin[1]), .s_result_o(res[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: RISC-V division semantics from plain arithmetic.
   function automatic logic [31:0] ref_model(input logic [1:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0;
      end else if (!f[0]) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end else begin
         q = a / b; r = a % b;
      end
      return f[1] ? r : q;
   endfunction

   function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   task automatic push_exp(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int hold);
      exp_t e;
      e.res       = exp;
      e.start_cyc = cyc;
      e.hold      = hold;
      e.lat       = is_special(f, a, b) ? 1 : 34;
      q0.push_back(e);
      e.lat       = 34;
      q1.push_back(e);
   endtask

   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      fn = f; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy != 2'b00 || fin != 2'b00) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         tests_run++; tests_failed++;
         $display("FAIL idle_timeout: busy %b finished %b after %0d cycles", busy, fin, n);
      end
   endtask

   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
      push_exp(f, a, b, exp, 1);
      issue(f, a, b);
      wait_idle();
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: pops the scoreboard when finished rises, tracks result stability and hold length.
   function automatic bit pop_exp(input int i, output exp_t e);
      if (i == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1.pop_front();
      end
      return 1'b1;
   endfunction

   initial begin
      logic        prev [2];
      int          hold [2];
      exp_t        cur  [2];
      logic [31:0] held [2];
      exp_t        e;
      for (int i = 0; i < 2; i++) begin
         prev[i] = 1'b0; hold[i] = 0; held[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (fin[i] === 1'b1 && !prev[i]) begin
               if (!pop_exp(i, e)) begin
                  tests_run++; tests_failed++;
                  $display("FAIL stale_finished[%0d]: got result %h with nothing outstanding", i, res[i]);
                  cur[i].hold = 1;
               end else begin
                  chk($sformatf("result[%0d]", i), res[i], e.res);
                  chk($sformatf("latency[%0d]", i), 32'(cyc - e.start_cyc), 32'(e.lat));
                  cur[i] = e;
               end
               hold[i] = 1;
               held[i] = res[i];
            end else if (fin[i] === 1'b1) begin
               hold[i]++;
               chk($sformatf("stable[%0d]", i), res[i], held[i]);
            end else if (prev[i]) begin
               chk($sformatf("hold_len[%0d]", i), 32'(hold[i]), 32'(cur[i].hold));
            end
            prev[i] = (fin[i] === 1'b1);
         end
      end
   end

   typedef struct { logic [1:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } dir_t;
   dir_t dir [9];

   initial begin
      logic [1:0]  rf;
      logic [31:0] ra, rb;
      int          n;

      dir[0] = '{DIV_FN_DIVU, 32'd100,        32'd7,          32'd14};
      dir[1] = '{DIV_FN_REMU, 32'd100,        32'd7,          32'd2};
      dir[2] = '{DIV_FN_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
      dir[3] = '{DIV_FN_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
      dir[4] = '{DIV_FN_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
      dir[5] = '{DIV_FN_REM,  32'd5,          32'd0,          32'd5};
      dir[6] = '{DIV_FN_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
      dir[7] = '{DIV_FN_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
      dir[8] = '{DIV_FN_DIVU, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};

      tests_run = 0; tests_failed = 0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; start = 1'b0;
      fn = '0; op1 = '0; op2 = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'd0);
         chk($sformatf("reset_finished[%0d]", i), 32'(fin[i]), 32'd0);
         chk($sformatf("reset_result[%0d]", i), res[i], 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_op(dir[i].f, dir[i].a, dir[i].b, dir[i].exp);

      // Stall held for three cycles in DONE: finished must stay up four cycles.
      stall = 1'b1;
      push_exp(DIV_FN_DIVU, 32'd1000, 32'd10, 32'd100, 4);
      issue(DIV_FN_DIVU, 32'd1000, 32'd10);
      n = 0;
      while (fin[0] !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("stall_reach_done", 32'(fin[0]), 32'd1);
      repeat (3) begin @(posedge clk); #1; end
      stall = 1'b0;
      wait_idle();

      // Flush in RUN cycle 10 aborts the operation with no later finished pulse.
      issue(DIV_FN_DIVU, 32'd123456, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_finished", 32'(fin), 32'd0);
      repeat (40) begin @(posedge clk); #1; end
      chk("flush_no_pulse", 32'(fin), 32'd0);
      run_op(DIV_FN_DIVU, 32'd9, 32'd3, 32'd3);

      // Reset mid-RUN clears every output.
      issue(DIV_FN_DIVU, 32'd100, 32'd7);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("midrst_busy[%0d]", i), 32'(busy[i]), 32'd0);
         chk($sformatf("midrst_finished[%0d]", i), 32'(fin[i]), 32'd0);
         chk($sformatf("midrst_result[%0d]", i), res[i], 32'd0);
      end
      repeat (40) begin @(posedge clk); #1; end

      // Start held high while busy must not restart the operation.
      push_exp(DIV_FN_DIVU, 32'd100, 32'd7, 32'd14, 1);
      fn = DIV_FN_DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
      start = 1'b0;
      wait_idle();

      for (int k = 0; k < 40; k++) begin
         rf = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: begin ra = $urandom; rb = 32'd0; end
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 20)); end
            3: begin ra = $urandom; rb = 32'($urandom_range(1, 300)) ^ {32{$urandom_range(0, 1) == 1}}; end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         run_op(rf, ra, rb, ref_model(rf, ra, rb));
      end

      repeat (5) begin @(posedge clk); #1; end
      chk("sb_empty[0]", 32'(q0.size()), 32'd0);
      chk("sb_empty[1]", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
